// File: rtl/i2c_master.sv
// Byte-level I2C master: START/repeated START, WRITE, READ and STOP on open-drain SCL/SDA.
// Optional macro I2C_MASTER_CLK_STRETCH_EN: the SCL-high quarter waits for the bus to read high.
module i2c_master #(
   parameter int unsigned CLK_DIV = 125
) (
   input  logic       in_clk,
   input  logic       in_rst_n,
   inout  wire        io_scl,
   inout  wire        io_sda,
   input  logic       in_cmd_valid,
   output logic       out_cmd_ready,
   input  logic [1:0] in_cmd,
   input  logic [7:0] in_wdata,
   input  logic       in_rd_nack,
   output logic [7:0] out_rdata,
   output logic       out_done,
   output logic       out_ack_err,
   output logic       out_arb_lost,
   output logic       out_cmd_err,
   output logic       out_busy
);

   localparam logic [1:0]  CMD_START = 2'd0;
   localparam logic [1:0]  CMD_WRITE = 2'd1;
   localparam logic [1:0]  CMD_READ  = 2'd2;
   localparam logic [15:0] CNT_MAX   = 16'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_RESTART, S_WR_BIT, S_WR_ACK, S_RD_BIT, S_RD_ACK, S_STOP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  qph_q, qph_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        nack_q, nack_d;
   logic        lost_q, lost_d;
   logic        scl_oe_q, scl_oe_d;
   logic        sda_oe_q, sda_oe_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ack_err_q, ack_err_d;
   logic        arb_q, arb_d;
   logic        cmd_err_q, cmd_err_d;
   logic [1:0]  scl_sync_q, sda_sync_q;
   logic        scl_in, sda_in, hold, phase_end;

   assign scl_in = scl_sync_q[1];
   assign sda_in = sda_sync_q[1];

`ifdef I2C_MASTER_CLK_STRETCH_EN
   // Freeze the quarter counter while SCL is released by us but still reads low.
   assign hold = !scl_oe_q && !scl_in &&
                 (((state_q == S_WR_BIT) || (state_q == S_WR_ACK) || (state_q == S_RD_BIT) ||
                   (state_q == S_RD_ACK) || (state_q == S_RESTART)) && (qph_q == 2'd2) ||
                  (state_q == S_STOP) && (qph_q == 2'd1));
`else
   assign hold = 1'b0;
`endif

   assign phase_end = (state_q != S_IDLE) && (cnt_q == CNT_MAX) && !hold;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      qph_d     = qph_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rdata_d   = rdata_q;
      nack_d    = nack_q;
      lost_d    = lost_q;
      scl_oe_d  = scl_oe_q;
      sda_oe_d  = sda_oe_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      arb_d     = 1'b0;
      cmd_err_d = 1'b0;
      if (state_q != S_IDLE && !hold) begin
         cnt_d = phase_end ? 16'd0 : cnt_q + 16'd1;
         if (phase_end) qph_d = qph_q + 2'd1;
      end
      case (state_q)
         S_IDLE: if (in_cmd_valid) begin
            cnt_d = 16'd0;
            qph_d = 2'd0;
            if (in_cmd == CMD_START) begin
               state_d  = busy_q ? S_RESTART : S_START;
               sda_oe_d = !busy_q;
            end else if (!busy_q) begin
               done_d    = 1'b1;
               cmd_err_d = 1'b1;
            end else if (in_cmd == CMD_WRITE) begin
               state_d  = S_WR_BIT;
               shift_d  = in_wdata;
               bit_d    = 3'd7;
               lost_d   = 1'b0;
               sda_oe_d = !in_wdata[7];
            end else if (in_cmd == CMD_READ) begin
               state_d  = S_RD_BIT;
               bit_d    = 3'd7;
               nack_d   = in_rd_nack;
               sda_oe_d = 1'b0;
            end else begin
               state_d  = S_STOP;
               sda_oe_d = 1'b1;
            end
         end
         S_START: if (phase_end) begin
            if (qph_q == 2'd0) scl_oe_d = 1'b1;
            else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         S_RESTART: if (phase_end) begin
            if (qph_q == 2'd1) scl_oe_d = 1'b0;
            else if (qph_q == 2'd2) sda_oe_d = 1'b1;
            else if (qph_q == 2'd3) begin
               // Bus now looks like a fresh START: finish with its SCL-low quarter.
               scl_oe_d = 1'b1;
               state_d  = S_START;
               qph_d    = 2'd1;
            end
         end
         S_WR_BIT: if (phase_end) begin
            if (qph_q == 2'd1) scl_oe_d = 1'b0;
            else if (qph_q == 2'd2) begin
               if (!sda_oe_q && !sda_in) lost_d = 1'b1;
            end else if (qph_q == 2'd3) begin
               if (lost_q) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  arb_d   = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  scl_oe_d = 1'b1;
                  if (bit_q == 3'd0) begin
                     state_d  = S_WR_ACK;
                     sda_oe_d = 1'b0;
                  end else begin
                     bit_d    = bit_q - 3'd1;
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = !shift_q[6];
                  end
               end
            end
         end
         S_WR_ACK: if (phase_end) begin
            if (qph_q == 2'd1) scl_oe_d = 1'b0;
            else if (qph_q == 2'd2) nack_d = sda_in;
            else if (qph_q == 2'd3) begin
               scl_oe_d  = 1'b1;
               state_d   = S_IDLE;
               done_d    = 1'b1;
               ack_err_d = nack_q;
            end
         end
         S_RD_BIT: if (phase_end) begin
            if (qph_q == 2'd1) scl_oe_d = 1'b0;
            else if (qph_q == 2'd2) shift_d = {shift_q[6:0], sda_in};
            else if (qph_q == 2'd3) begin
               scl_oe_d = 1'b1;
               if (bit_q == 3'd0) begin
                  state_d  = S_RD_ACK;
                  sda_oe_d = !nack_q;
               end else begin
                  bit_d = bit_q - 3'd1;
               end
            end
         end
         S_RD_ACK: if (phase_end) begin
            if (qph_q == 2'd1) scl_oe_d = 1'b0;
            else if (qph_q == 2'd3) begin
               scl_oe_d = 1'b1;
               state_d  = S_IDLE;
               done_d   = 1'b1;
               rdata_d  = shift_q;
            end
         end
         S_STOP: if (phase_end) begin
            if (qph_q == 2'd0) scl_oe_d = 1'b0;
            else if (qph_q == 2'd1) sda_oe_d = 1'b0;
            else begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         qph_q      <= 2'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         rdata_q    <= 8'd0;
         nack_q     <= 1'b0;
         lost_q     <= 1'b0;
         scl_oe_q   <= 1'b0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         arb_q      <= 1'b0;
         cmd_err_q  <= 1'b0;
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         qph_q      <= qph_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         rdata_q    <= rdata_d;
         nack_q     <= nack_d;
         lost_q     <= lost_d;
         scl_oe_q   <= scl_oe_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
         arb_q      <= arb_d;
         cmd_err_q  <= cmd_err_d;
         scl_sync_q <= {scl_sync_q[0], io_scl};
         sda_sync_q <= {sda_sync_q[0], io_sda};
      end
   end

   assign io_scl        = scl_oe_q ? 1'b0 : 1'bz;
   assign io_sda        = sda_oe_q ? 1'b0 : 1'bz;
   assign out_cmd_ready = (state_q == S_IDLE);
   assign out_rdata     = rdata_q;
   assign out_done      = done_q;
   assign out_ack_err   = ack_err_q;
   assign out_arb_lost  = arb_q;
   assign out_cmd_err   = cmd_err_q;
   assign out_busy      = busy_q;

endmodule

// File: doc/i2c_master.md
# i2c_master

Byte-level I2C bus master driving open-drain SCL and SDA from the system clock. It executes one command per handshake: START/repeated START, WRITE byte with slave-ACK check, READ byte with master ACK/NACK, and STOP. It is the initiator counterpart of the team's I2C slave and drives it, and other I2C peripherals, from on-chip control logic.

## Interface
- `CLK_DIV`, default 125: in_clk cycles per SCL quarter-period; SCL period = 4*CLK_DIV cycles. 125 at 50 MHz gives 100 kHz. Legal range 2..65535.
- `in_clk`  in  1  system clock; all logic on the rising edge.
- `in_rst_n`  in  1  asynchronous, active-low reset.
- `io_scl`  inout  1  open-drain SCL; driven 0 or released to 'z'.
- `io_sda`  inout  1  open-drain SDA; driven 0 or released to 'z'.
- `in_cmd_valid`  in  1  command request.
- `out_cmd_ready`  out  1  accepts a command when high.
- `in_cmd`  in  2  0=START, 1=WRITE, 2=READ, 3=STOP.
- `in_wdata`  in  8  byte for WRITE, captured at accept.
- `in_rd_nack`  in  1  for READ: 1 = send NACK after the byte, 0 = ACK; captured at accept.
- `out_rdata`  out  8  last READ byte; valid from out_done until the next READ completes.
- `out_done`  out  1  one-cycle pulse when a command finishes.
- `out_ack_err`  out  1  with out_done for WRITE: slave returned NACK.
- `out_arb_lost`  out  1  with out_done: arbitration lost.
- `out_cmd_err`  out  1  with out_done: illegal command for the bus state.
- `out_busy`  out  1  master owns the bus, from START until STOP completes.

## Operation
- Reset values: both lines released, out_cmd_ready=1, out_rdata=0, all other outputs 0, state IDLE.
- Handshake: a command is accepted when in_cmd_valid && out_cmd_ready. out_cmd_ready drops the next cycle and rises in the same cycle as out_done.
- SDA and SCL inputs pass through 2-FF synchronizers. Sample points below refer to synchronized values.
- Bit timing uses a quarter-phase counter, Q0..Q3:
  - Q0, Q1: SCL low. SDA changes only at the start of Q0.
  - Q2, Q3: SCL released. Sampling happens at the end of Q2.
- States: IDLE, START, RESTART, WR_BIT, WR_ACK, RD_BIT, RD_ACK, STOP.
- START from IDLE:
  - SDA falls while SCL is high.
  - After CLK_DIV cycles, SCL goes low.
  - out_done follows, and out_busy=1.
- START while out_busy: RESTART. Release SDA in Q0/Q1, release SCL in Q2, pull SDA low in Q3, then behave as START.
- WRITE: 8 bits MSB first, then a 9th bit with SDA released. out_ack_err = sampled SDA on the 9th bit.
- Arbitration: if a released data bit samples 0 during WRITE, release SDA at once and finish the current SCL cycle. Then pulse out_done with out_arb_lost=1, clear out_busy, and return to IDLE without issuing STOP.
- READ:
  - SDA is released for 8 bits, sampled MSB first into a shift register.
  - The 9th bit drives SDA low if in_rd_nack=0, and releases it if in_rd_nack=1.
  - out_rdata updates together with out_done.
- STOP:
  - SDA is low during SCL low.
  - SCL is released, then SDA is released CLK_DIV cycles later.
  - out_done follows, with out_busy=0.
- Illegal commands:
  - WRITE, READ or STOP while !out_busy completes in 1 cycle with out_done and out_cmd_err=1.
  - No line activity occurs.
- Reset mid-transfer releases both lines asynchronously. No STOP is generated.

## Timing
- START: 2*CLK_DIV+1 cycles from accept to out_done.
- WRITE/READ: 9*4*CLK_DIV+1 cycles.
- STOP: 3*CLK_DIV+1 cycles.
- RESTART: 4*CLK_DIV+CLK_DIV+1 cycles.
- Each command ends with SCL low, except STOP and arbitration loss.
- Add 2 cycles of synchronizer latency to each sample point.

## Configuration
- `I2C_MASTER_CLK_STRETCH_EN` defined: in Q2 the counter holds until synchronized SCL reads 1, which supports slave clock stretching. Q3 starts only after that, so all latencies above grow by the stretch time.
- Not defined: SCL is assumed high once released, and timing is exactly as specified.

## Test plan
- Write, CLK_DIV=4, slave model at 0x50 ACKs: START, WRITE 0xA0, WRITE 0x12, STOP.
  - SDA bits are MSB first and stable while SCL is high.
  - Three done pulses with ack_err=0, then STOP; busy returns to 0.
- NACK: START, WRITE 0xA4 with no slave at 0x52 -> out_done with out_ack_err=1; busy stays 1 until STOP.
- Read: START, WRITE 0xA1, READ with in_rd_nack=1, slave returns 0xAA.
  - out_rdata=0xAA.
  - SDA is released during the 9th SCL high.
  - STOP follows with SDA rising while SCL is high.
- Repeated start: START, WRITE 0xA0, START -> SDA falls while SCL is high without an intervening STOP, and busy stays 1.
- Errors:
  - WRITE in IDLE -> done+cmd_err next cycle, lines stay high.
  - Second master forces SDA=0 on bit 2 of WRITE 0xFF -> arb_lost=1, busy=0, lines released.
- Reset mid-byte: drop in_rst_n at bit 4 of WRITE -> io_scl/io_sda 'z' the same cycle; after release, ready=1 and all flags are 0.
